// File: rtl/des_pkg.sv
// des_pkg: shared constants and the controller state type for the
// SPI-fronted DES transaction sequencer.
//   BLOCK_W / KEY_W        : width of a DES block and of a DES key
//   FRAME_BITS_DEFAULT     : sclk rising edges that make a valid frame
//   DONE_TIMEOUT_DEFAULT   : clk cycles allowed for the DES core to answer
//   CNT_W                  : width of the saturating frame bit counter
//   ctrl_state_t           : controller FSM states
package des_pkg;

    localparam int BLOCK_W              = 64;
    localparam int KEY_W                = 64;
    localparam int FRAME_BITS_DEFAULT   = 64;
    localparam int DONE_TIMEOUT_DEFAULT = 255;
    localparam int CNT_W                = 8;

    typedef enum logic [1:0] {
        WAIT_KEY = 2'd0,
        IDLE     = 2'd1,
        RUN      = 2'd2,
        RESULT   = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/spi_frame_mon.sv
// spi_frame_mon: brings the raw SPI chip select and serial clock into the
// clk domain, detects their edges and counts sclk rising edges per frame.
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   spi_cs_n     : raw chip select (active low, asynchronous)
//   spi_sclk     : raw serial clock (asynchronous)
//   cs_low_sync  : synchronised chip select is asserted (low)
//   cs_fall      : one-cycle pulse, synchronised chip select fell
//   frame_ok     : one-cycle pulse, frame ended with exactly FRAME_BITS bits
//   frame_bad    : one-cycle pulse, frame ended with any other bit count
module spi_frame_mon
    import des_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = FRAME_BITS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_cs_n,
    input  logic spi_sclk,
    output logic cs_low_sync,
    output logic cs_fall,
    output logic frame_ok,
    output logic frame_bad
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic                   cs_s;
    logic                   sclk_s;
    logic                   cs_d;
    logic                   sclk_d;
    logic                   cs_rise;
    logic                   sclk_rise;
    logic [CNT_W-1:0]       bit_cnt;

    // Chip select idles high, so its synchroniser and delayed copy reset
    // to 1; otherwise a spurious cs_fall would follow every reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            cs_d      <= 1'b1;
            sclk_d    <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_d      <= cs_s;
            sclk_d    <= sclk_s;
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_d & ~cs_s;
    assign cs_rise   = ~cs_d & cs_s;
    assign sclk_rise = ~sclk_d & sclk_s;

    // The counter saturates so that very long frames can never wrap back
    // onto FRAME_BITS and be mistaken for a valid frame. A clock edge that
    // lands in the same cycle as the chip-select fall is the first bit of
    // the new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (cs_fall) begin
            bit_cnt <= sclk_rise ? CNT_W'(1) : '0;
        end else if (sclk_rise && !cs_s && bit_cnt != CNT_MAX) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    assign cs_low_sync = ~cs_s;
    assign frame_ok    = cs_rise & (bit_cnt == FRAME_CNT);
    assign frame_bad   = cs_rise & (bit_cnt != FRAME_CNT);

endmodule

// File: rtl/des_spi_ctrl.sv
// des_spi_ctrl: runs one DES transaction per SPI frame. The first valid
// frame after reset or rekey is the key; every later valid frame is a data
// block whose DES result is handed back to the SPI slave for the next frame.
// Ports:
//   clk, rst          : system clock, asynchronous active-high reset
//   spi_cs_n/spi_sclk : raw SPI chip select and serial clock
//   spi_input_text    : word received by the SPI slave
//   spi_output_text   : word the SPI slave shifts out in the next frame
//   decrypt           : mode for data blocks, captured with the block
//   rekey             : level, forces a return to key loading
//   err_clr           : pulse, clears the sticky error flags
//   des_start/des_decrypt/des_key/des_block_in : request to the DES core
//   des_done/des_block_out                     : answer from the DES core
//   key_loaded, busy  : status
//   frame_err, overrun, timeout_err : sticky error flags
//   fsm_state         : current controller state (ctrl_state_t encoding)
module des_spi_ctrl
    import des_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int FRAME_BITS   = FRAME_BITS_DEFAULT,
    parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spi_cs_n,
    input  logic               spi_sclk,
    input  logic [BLOCK_W-1:0] spi_input_text,
    output logic [BLOCK_W-1:0] spi_output_text,
    input  logic               decrypt,
    input  logic               rekey,
    input  logic               err_clr,
    output logic               des_start,
    output logic               des_decrypt,
    output logic [KEY_W-1:0]   des_key,
    output logic [BLOCK_W-1:0] des_block_in,
    input  logic               des_done,
    input  logic [BLOCK_W-1:0] des_block_out,
    output logic               key_loaded,
    output logic               busy,
    output logic               frame_err,
    output logic               overrun,
    output logic               timeout_err,
    output logic [1:0]         fsm_state
);

    localparam int               TMO_W     = $clog2(DONE_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(DONE_TIMEOUT);

    ctrl_state_t        state;
    ctrl_state_t        state_next;
    logic               cs_low_sync;
    logic               cs_fall;
    logic               frame_ok;
    logic               frame_bad;
    logic               cap_key;
    logic               cap_blk;
    logic               lat_res;
    logic               load_out;
    logic               tmo_hit;
    logic               ovr_hit;
    logic               start_q;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [BLOCK_W-1:0] result_q;

    spi_frame_mon #(
        .SYNC_STAGES (SYNC_STAGES),
        .FRAME_BITS  (FRAME_BITS)
    ) u_frame_mon (
        .clk         (clk),
        .rst         (rst),
        .spi_cs_n    (spi_cs_n),
        .spi_sclk    (spi_sclk),
        .cs_low_sync (cs_low_sync),
        .cs_fall     (cs_fall),
        .frame_ok    (frame_ok),
        .frame_bad   (frame_bad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_KEY;
        end else begin
            state <= state_next;
        end
    end

    // DES core handshake: des_start is a single-cycle request issued the
    // cycle after the block is captured; des_key, des_block_in and
    // des_decrypt are held stable until the next request. The core answers
    // with a single-cycle des_done carrying des_block_out. A des_done seen
    // outside RUN (late answer after rekey or timeout) is discarded.
    always_comb begin
        state_next = state;
        cap_key    = 1'b0;
        cap_blk    = 1'b0;
        lat_res    = 1'b0;
        load_out   = 1'b0;
        tmo_hit    = 1'b0;
        ovr_hit    = 1'b0;
        if (rekey) begin
            state_next = WAIT_KEY;
        end else begin
            case (state)
                WAIT_KEY: begin
                    if (frame_ok) begin
                        cap_key    = 1'b1;
                        state_next = IDLE;
                    end
                end
                IDLE: begin
                    if (frame_ok) begin
                        cap_blk    = 1'b1;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    ovr_hit = frame_ok;
                    if (des_done) begin
                        lat_res    = 1'b1;
                        state_next = RESULT;
                    end else if (tmo_cnt == TMO_LIMIT) begin
                        tmo_hit    = 1'b1;
                        state_next = IDLE;
                    end
                end
                RESULT: begin
                    ovr_hit = frame_ok;
                    // The slave may be mid-shift while CS is low; only swap
                    // its transmit word once the bus is idle.
                    if (!cs_low_sync && !cs_fall) begin
                        load_out   = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = WAIT_KEY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            des_key         <= '0;
            key_loaded      <= 1'b0;
            des_block_in    <= '0;
            des_decrypt     <= 1'b0;
            start_q         <= 1'b0;
            result_q        <= '0;
            spi_output_text <= '0;
            tmo_cnt         <= '0;
            frame_err       <= 1'b0;
            overrun         <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            start_q <= cap_blk;
            if (cap_key) begin
                des_key    <= spi_input_text;
                key_loaded <= 1'b1;
            end
            if (cap_blk) begin
                des_block_in <= spi_input_text;
                des_decrypt  <= decrypt;
            end
            if (lat_res) begin
                result_q <= des_block_out;
            end
            if (load_out) begin
                spi_output_text <= result_q;
            end
            if (rekey) begin
                des_key         <= '0;
                key_loaded      <= 1'b0;
                spi_output_text <= '0;
            end
            if (cap_blk) begin
                tmo_cnt <= '0;
            end else if (state == RUN && tmo_cnt != TMO_LIMIT) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            // A new error event in the same cycle as err_clr keeps the flag.
            frame_err   <= frame_bad | (frame_err & ~err_clr);
            overrun     <= ovr_hit | (overrun & ~err_clr);
            timeout_err <= tmo_hit | (timeout_err & ~err_clr);
        end
    end

    // A rekey arriving on the start cycle withdraws the request.
    assign des_start = start_q & ~rekey;
    assign busy      = (state == RUN);
    assign fsm_state = state;

endmodule
